// File: rtl/bsg_fpu_pkg.sv
// Half-precision constants and pipeline records shared by the FPU pack/unpack stages.
package bsg_fpu_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] NAN_CANON = 16'h7E00;
  localparam logic [14:0] INF_MAG   = 15'h7C00;
  localparam logic [4:0]  EXP_MAX   = 5'h1F;

  // normalized beat held between stage 1 and stage 2; e is two's complement
  typedef struct packed {
    logic        sign;
    logic [7:0]  e;
    logic [13:0] man;
    logic        nan;
    logic        infty;
    logic        zero;
  } fpu_pp_s1_t;

  typedef struct packed {
    logic [15:0] z;
    logic        overflow;
    logic        underflow;
    logic        inexact;
  } fpu_pp_resp_t;

endpackage

// File: rtl/bsg_fpu_clz14.sv
// Combinational leading-zero count of a 14-bit significand; all-zero input reports 13.
module bsg_fpu_clz14 (
  input  logic [13:0] a_i,
  output logic [3:0]  num_zero_o
);

  always_comb begin
    num_zero_o = 4'd13;
    // scanning upward, the last set bit seen is the most significant one
    for (int i = 0; i < 14; i++)
      if (a_i[i]) num_zero_o = 4'(13 - i);
  end

endmodule

// File: rtl/bsg_fpu_postprocess.sv
// Two-stage half-precision packer: normalize, then round-to-nearest-even and pack with
// overflow / denormal / special handling. valid/ready in, valid/yumi out.
module bsg_fpu_postprocess
  import bsg_fpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        v_i,
  output logic        ready_o,
  input  logic        sign_i,
  input  logic [6:0]  exp_i,
  input  logic [13:0] man_i,
  input  logic        nan_i,
  input  logic        infty_i,
  input  logic        zero_i,
  output logic        v_o,
  input  logic        yumi_i,
  output logic [15:0] z_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        inexact_o
);

  logic [2:1]   vld_pipe;
  logic         s1_adv, s2_adv;
  logic [3:0]   lzc;
  fpu_pp_s1_t   s1_d, s1_q;
  fpu_pp_resp_t resp_d, resp_q;

  assign s2_adv  = ~vld_pipe[2] | yumi_i;
  assign s1_adv  = ~vld_pipe[1] | s2_adv;
  assign ready_o = s1_adv;

  bsg_fpu_clz14 clz (.a_i(man_i), .num_zero_o(lzc));

  always_comb begin
    s1_d       = '0;
    s1_d.sign  = sign_i;
    s1_d.e     = {exp_i[6], exp_i} - {4'b0, lzc};
    s1_d.man   = man_i << lzc;
    s1_d.nan   = nan_i;
    s1_d.infty = infty_i;
    s1_d.zero  = zero_i | (man_i == '0);
  end

  // stage 2: denormal shift, RNE, pack
  logic        tiny, big, guard, sticky, round_up, inexact, ovf;
  logic [8:0]  sh_full;
  logic [3:0]  shamt;
  logic [27:0] den_ext;
  logic [9:0]  man10;
  logic [4:0]  expf;
  logic [14:0] rounded;

  always_comb begin
    tiny     = s1_q.e[7] | (s1_q.e == '0);
    big      = ~tiny & ($signed(s1_q.e) >= 8'sd31);
    sh_full  = 9'd1 - {s1_q.e[7], s1_q.e};
    shamt    = ~tiny ? 4'd0 : (sh_full > 9'd15) ? 4'd15 : sh_full[3:0];
    // hidden bit drops off the top; everything shifted below bit 0 lands in the low 15 bits
    den_ext  = 28'({s1_q.man, 15'b0} >> shamt);
    man10    = den_ext[27:18];
    guard    = den_ext[17];
    sticky   = |den_ext[16:0];
    round_up = guard & (sticky | man10[0]);
    expf     = tiny ? 5'd0 : s1_q.e[4:0];
    rounded  = {expf, man10} + 15'(round_up);
    ovf      = big | (rounded[14:10] == EXP_MAX);
    inexact  = guard | sticky;

    resp_d = '0;
    if (s1_q.nan)        resp_d.z = NAN_CANON;
    else if (s1_q.infty) resp_d.z = {s1_q.sign, INF_MAG};
    else if (s1_q.zero)  resp_d.z = {s1_q.sign, 15'h0};
    else if (ovf) begin
      resp_d.z        = {s1_q.sign, INF_MAG};
      resp_d.overflow = 1'b1;
      resp_d.inexact  = 1'b1;
    end else begin
      resp_d.z         = {s1_q.sign, rounded};
      resp_d.underflow = tiny & inexact;
      resp_d.inexact   = inexact;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      resp_q   <= '0;
    end else begin
      if (s1_adv) begin
        vld_pipe[1] <= v_i;
        if (v_i) s1_q <= s1_d;
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) resp_q <= resp_d;
      end
    end
  end

  assign v_o         = vld_pipe[2];
  assign z_o         = resp_q.z;
  assign overflow_o  = resp_q.overflow;
  assign underflow_o = resp_q.underflow;
  assign inexact_o   = resp_q.inexact;

endmodule

// File: tb/tb_bsg_fpu_postprocess.sv
// Self-checking bench for bsg_fpu_postprocess: directed table, randomized flow vs a value model,
// backpressure and mid-stream reset sequences.
module tb_bsg_fpu_postprocess;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        v_i, ready_o, sign_i, nan_i, infty_i, zero_i;
  logic [6:0]  exp_i;
  logic [13:0] man_i;
  logic        v_o, yumi_i;
  logic [15:0] z_o;
  logic        overflow_o, underflow_o, inexact_o;
  logic [18:0] res;

  int errors = 0;
  int checks = 0;

  bsg_fpu_postprocess dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .man_i(man_i), .nan_i(nan_i), .infty_i(infty_i),
    .zero_i(zero_i), .v_o(v_o), .yumi_i(yumi_i), .z_o(z_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o), .inexact_o(inexact_o)
  );

  always #5 clk_i = ~clk_i;
  assign res = {z_o, overflow_o, underflow_o, inexact_o};

  typedef struct {
    logic        s;
    logic [6:0]  e;
    logic [13:0] m;
    logic        nan, inf, zr;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[13];
  logic [18:0] q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // exact value man*2^(exp-28), quantized to the half-precision grid with RNE
  function automatic logic [18:0] model(input logic s, input logic [6:0] ex, input logic [13:0] m,
                                        input logic nan, input logic inf, input logic zr);
    int e, p, eb, k, sh;
    longint qv, rem, half, mag;
    bit inex, up;
    if (nan) return {16'h7E00, 3'b000};
    if (inf) return {s, 15'h7C00, 3'b000};
    if (zr || m == 0) return {s, 15'h0, 3'b000};
    e = int'($signed(ex));
    p = 0;
    for (int i = 0; i < 14; i++) if (m[i]) p = i;
    eb = e - (13 - p);
    k = e - 3 - ((eb >= 1) ? eb : 1);
    inex = 0; up = 0;
    if (k >= 0) qv = longint'(m) << k;
    else begin
      sh = -k;
      if (sh > 40) begin qv = 0; inex = 1; end
      else begin
        qv   = longint'(m) >> sh;
        rem  = longint'(m) - (qv << sh);
        half = longint'(1) << (sh - 1);
        inex = (rem != 0);
        up   = (rem > half) || (rem == half && qv[0]);
      end
    end
    qv  = qv + longint'(up);
    mag = (eb >= 1) ? ((longint'(eb) << 10) + qv - 1024) : qv;
    if (eb >= 31 || mag >= 31 * 1024) return {s, 15'h7C00, 3'b101};
    return {s, mag[14:0], 1'b0, (eb <= 0) && inex, inex};
  endfunction

  task automatic drive(input vec_t v);
    sign_i = v.s; exp_i = v.e; man_i = v.m; nan_i = v.nan; infty_i = v.inf; zero_i = v.zr;
  endtask

  task automatic drive_rand();
    int r;
    r = $urandom_range(0, 15);
    sign_i  = 1'($urandom);
    exp_i   = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'($urandom_range(0, 40)) - 7'd5;
    man_i   = 14'($urandom) >> $urandom_range(0, 13);
    nan_i   = (r == 0);
    infty_i = (r == 1) || (r == 3);
    zero_i  = (r == 2) || (r == 3);
  endtask

  // one isolated beat on an empty pipe: check two-edge latency and the packed result
  task automatic send_one(input vec_t v, input string name);
    int cyc;
    @(negedge clk_i);
    drive(v); v_i = 1'b1; yumi_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    v_i = 1'b0; cyc = 1;
    while (!v_o && cyc < 8) begin
      @(posedge clk_i); @(negedge clk_i); cyc++;
    end
    chk({name, "_lat"}, cyc, 2);
    chk(name, res, v.exp);
    yumi_i = v_o;
    @(posedge clk_i);
    @(negedge clk_i);
    yumi_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int inflight, sent, got_n, bp_n;
    logic stall_pend;
    logic [18:0] held;
    logic [18:0] bp_exp[5];

    tbl[0]  = '{1'b0, 7'd15,  14'h2000, 1'b0, 1'b0, 1'b0, {16'h3C00, 3'b000}};
    tbl[1]  = '{1'b0, 7'd15,  14'h2004, 1'b0, 1'b0, 1'b0, {16'h3C00, 3'b001}};
    tbl[2]  = '{1'b0, 7'd15,  14'h200C, 1'b0, 1'b0, 1'b0, {16'h3C02, 3'b001}};
    tbl[3]  = '{1'b0, 7'd15,  14'h0001, 1'b0, 1'b0, 1'b0, {16'h0800, 3'b000}};
    tbl[4]  = '{1'b0, 7'd30,  14'h3FFC, 1'b0, 1'b0, 1'b0, {16'h7C00, 3'b101}};
    tbl[5]  = '{1'b1, 7'd40,  14'h2000, 1'b0, 1'b0, 1'b0, {16'hFC00, 3'b101}};
    tbl[6]  = '{1'b0, 7'd0,   14'h2000, 1'b0, 1'b0, 1'b0, {16'h0200, 3'b000}};
    tbl[7]  = '{1'b0, 7'h6C,  14'h2000, 1'b0, 1'b0, 1'b0, {16'h0000, 3'b011}};
    tbl[8]  = '{1'b0, 7'd0,   14'h3FFC, 1'b0, 1'b0, 1'b0, {16'h0400, 3'b011}};
    tbl[9]  = '{1'b1, 7'd15,  14'h2000, 1'b1, 1'b0, 1'b0, {16'h7E00, 3'b000}};
    tbl[10] = '{1'b1, 7'd15,  14'h2000, 1'b0, 1'b1, 1'b1, {16'hFC00, 3'b000}};
    tbl[11] = '{1'b1, 7'd15,  14'h0000, 1'b0, 1'b0, 1'b0, {16'h8000, 3'b000}};
    tbl[12] = '{1'b0, 7'd1,   14'h2000, 1'b0, 1'b0, 1'b0, {16'h0400, 3'b000}};

    reset_n_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    chk("rst_v_o", v_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_out", res, 0);

    foreach (tbl[i]) send_one(tbl[i], $sformatf("vec%0d", i));

    // randomized traffic against the value model, with ready and stall-hold checks
    stall_pend = 1'b0; held = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_i);
      if (stall_pend) chk("stall_hold", res, held);
      stall_pend = 1'b0;
      inflight = q.size();
      yumi_i = v_o && ($urandom_range(0, 3) != 0);
      if (v_o && yumi_i) begin
        if (q.size() == 0) chk("rand_extra_out", 1, 0);
        else chk("rand", res, q.pop_front());
      end else if (v_o) begin
        stall_pend = 1'b1; held = res;
      end
      drive_rand();
      v_i = (i < 560) && ($urandom_range(0, 3) != 0);
      #1;
      chk("rand_ready", ready_o, (inflight < 2) || yumi_i);
      if (v_i && ready_o) q.push_back(model(sign_i, exp_i, man_i, nan_i, infty_i, zero_i));
    end
    v_i = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk_i);
      yumi_i = v_o;
      if (v_o) chk("drain", res, q.pop_front());
    end
    chk("drain_empty", q.size(), 0);
    @(negedge clk_i);
    yumi_i = 1'b0;

    // backpressure: yumi held low at the start, five beats streamed back to back
    for (int i = 0; i < 5; i++) bp_exp[i] = tbl[i].exp;
    sent = 0; got_n = 0; bp_n = 0; stall_pend = 1'b0;
    for (int cyc = 0; cyc < 40 && got_n < 5; cyc++) begin
      @(negedge clk_i);
      if (stall_pend) chk("bp_stall_hold", res, held);
      stall_pend = 1'b0;
      yumi_i = (cyc >= 4) && v_o;
      if (v_o && yumi_i) begin
        chk($sformatf("bp_out%0d", got_n), res, bp_exp[got_n]);
        got_n++;
      end else if (v_o) begin
        stall_pend = 1'b1; held = res;
      end
      v_i = (sent < 5);
      if (sent < 5) drive(tbl[sent]);
      #1;
      if (cyc == 2) begin
        chk("bp_ready_drop", ready_o, 0);
        chk("bp_accepts", sent, 2);
      end
      if (v_i && ready_o) sent++;
    end
    chk("bp_count", got_n, 5);
    @(negedge clk_i);
    v_i = 1'b0; yumi_i = 1'b0;
    @(negedge clk_i);
    chk("bp_no_dup", v_o, 0);

    // mid-stream reset discards in-flight beats
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      drive(tbl[i + 2]); v_i = 1'b1;
    end
    @(negedge clk_i);
    v_i = 1'b1; reset_n_i = 1'b0;
    @(negedge clk_i);
    v_i = 1'b0; reset_n_i = 1'b1;
    chk("mid_rst_v_o", v_o, 0);
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_out", res, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_rst_flushed", v_o, 0);
    send_one(tbl[2], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
